// File: rtl/synchronous_multichannel_fifo_pkg.sv
// ----------------------------------------------------------------------------
// synchronous_multichannel_fifo_pkg
//   Shared constants and helpers for the multichannel FIFO slice.
//   Contents:
//     clog2()  - ceiling log2, used to size pointers and RAM addresses
// ----------------------------------------------------------------------------
package synchronous_multichannel_fifo_pkg;

    // Ceiling log2; clog2(1) = 0. Usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/synchronous_multichannel_fifo_ram.sv
// ----------------------------------------------------------------------------
// simple_dual_port_ram
//   One write port, one asynchronous read port. Contents are never reset.
//   Ports:
//     clock_i       - write clock (rising edge)
//     write_en_i    - write strobe
//     write_addr_i  - write address
//     write_data_i  - write data
//     read_addr_i   - read address
//     read_data_o   - data at read_addr_i (combinational, no write bypass)
// ----------------------------------------------------------------------------
module simple_dual_port_ram
    import synchronous_multichannel_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clock_i,
    input  logic              write_en_i,
    input  logic [ADDR_W-1:0] write_addr_i,
    input  logic [WIDTH-1:0]  write_data_i,
    input  logic [ADDR_W-1:0] read_addr_i,
    output logic [WIDTH-1:0]  read_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock_i) begin
        if (write_en_i) begin
            mem_q[write_addr_i] <= write_data_i;
        end
    end

    assign read_data_o = mem_q[read_addr_i];

endmodule

// File: rtl/synchronous_multichannel_fifo.sv
// ----------------------------------------------------------------------------
// synchronous_multichannel_fifo
//   CHANNELS independent FIFO queues of DEPTH entries sharing one simple
//   dual-port RAM. Each cycle one push and one pop, each to its own channel.
//
//   Optional feature macro: SYNCHRONOUS_MULTICHANNEL_FIFO_ERROR_EN
//     When defined, adds sticky per-channel write_overflow_o / read_underflow_o
//     flags, set on a dropped push / dropped pop and cleared only by reset.
//
//   Handshake: a push is accepted when write_enable_i is high and the selected
//   channel is not full; a pop is accepted when read_enable_i is high and the
//   selected channel is not empty. Full/empty are taken from the pre-edge
//   pointers only, so a same-channel push+pop never relieves its own
//   full/empty condition. Refused operations change no state.
//
//   Ports:
//     clock_i          - clock, all logic on rising edge
//     reset_i          - synchronous active-high reset (pointers only)
//     write_enable_i   - push request
//     write_channel_i  - channel to push into
//     write_data_i     - data to push
//     write_full_o     - per-channel full
//     read_enable_i    - pop request
//     read_channel_i   - channel to read/pop
//     read_data_o      - head of read_channel_i (combinational)
//     read_empty_o     - per-channel empty
//     level_o          - per-channel entry count, DEPTH_LOG2+1 bits each
// ----------------------------------------------------------------------------
module synchronous_multichannel_fifo
    import synchronous_multichannel_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int CHANNELS = 4,
    localparam int DEPTH_LOG2   = clog2(DEPTH),
    localparam int CHANNEL_LOG2 = clog2(CHANNELS),
    localparam int PTR_W        = DEPTH_LOG2 + 1
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      write_enable_i,
    input  logic [CHANNEL_LOG2-1:0]   write_channel_i,
    input  logic [WIDTH-1:0]          write_data_i,
    output logic [CHANNELS-1:0]       write_full_o,
    input  logic                      read_enable_i,
    input  logic [CHANNEL_LOG2-1:0]   read_channel_i,
    output logic [WIDTH-1:0]          read_data_o,
    output logic [CHANNELS-1:0]       read_empty_o,
`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_ERROR_EN
    output logic [CHANNELS-1:0]       write_overflow_o,
    output logic [CHANNELS-1:0]       read_underflow_o,
`endif
    output logic [CHANNELS*PTR_W-1:0] level_o
);

    localparam int RAM_DEPTH = CHANNELS * DEPTH;
    localparam int ADDR_W    = CHANNEL_LOG2 + DEPTH_LOG2;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] wr_ptr_q [CHANNELS];
    logic [PTR_W-1:0] wr_ptr_d [CHANNELS];
    logic [PTR_W-1:0] rd_ptr_q [CHANNELS];
    logic [PTR_W-1:0] rd_ptr_d [CHANNELS];

    logic             push_ok;
    logic             pop_ok;
    logic [ADDR_W-1:0] ram_write_addr;
    logic [ADDR_W-1:0] ram_read_addr;

    // Status decode: registered pointers only, no input dependence.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_status
        assign read_empty_o[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
        assign write_full_o[c] =
            (wr_ptr_q[c][DEPTH_LOG2-1:0] == rd_ptr_q[c][DEPTH_LOG2-1:0]) &&
            (wr_ptr_q[c][DEPTH_LOG2] != rd_ptr_q[c][DEPTH_LOG2]);
        assign level_o[c*PTR_W +: PTR_W] = wr_ptr_q[c] - rd_ptr_q[c];
    end

    assign push_ok = write_enable_i && !write_full_o[write_channel_i];
    assign pop_ok  = read_enable_i  && !read_empty_o[read_channel_i];

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
        end
        if (push_ok) begin
            wr_ptr_d[write_channel_i] = wr_ptr_q[write_channel_i] + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d[read_channel_i] = rd_ptr_q[read_channel_i] + PTR_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (reset_i) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end else begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
            end
        end
    end

`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_ERROR_EN
    logic [CHANNELS-1:0] overflow_q;
    logic [CHANNELS-1:0] overflow_d;
    logic [CHANNELS-1:0] underflow_q;
    logic [CHANNELS-1:0] underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (write_enable_i && write_full_o[write_channel_i]) begin
            overflow_d[write_channel_i] = 1'b1;
        end
        if (read_enable_i && read_empty_o[read_channel_i]) begin
            underflow_d[read_channel_i] = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            overflow_q  <= '0;
            underflow_q <= '0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign write_overflow_o = overflow_q;
    assign read_underflow_o = underflow_q;
`endif

    // Each channel owns a contiguous DEPTH-entry slice of the shared RAM.
    assign ram_write_addr = {write_channel_i, wr_ptr_q[write_channel_i][DEPTH_LOG2-1:0]};
    assign ram_read_addr  = {read_channel_i,  rd_ptr_q[read_channel_i][DEPTH_LOG2-1:0]};

    simple_dual_port_ram #(
        .WIDTH (WIDTH),
        .DEPTH (RAM_DEPTH)
    ) u_ram (
        .clock_i      (clock_i),
        .write_en_i   (push_ok),
        .write_addr_i (ram_write_addr),
        .write_data_i (write_data_i),
        .read_addr_i  (ram_read_addr),
        .read_data_o  (read_data_o)
    );

endmodule

// File: tb/tb_synchronous_multichannel_fifo.sv
module tb_synchronous_multichannel_fifo;

    logic        clock;
    logic        reset;
    logic        write_enable;
    logic [1:0]  write_channel;
    logic [7:0]  write_data;
    logic [3:0]  write_full;
    logic        read_enable;
    logic [1:0]  read_channel;
    logic [7:0]  read_data;
    logic [3:0]  read_empty;
    logic [11:0] level;
`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_ERROR_EN
    logic [3:0]  write_overflow;
    logic [3:0]  read_underflow;
`endif

    int checks = 0;
    int errors = 0;

    synchronous_multichannel_fifo #(
        .WIDTH    (8),
        .DEPTH    (4),
        .CHANNELS (4)
    ) dut (
        .clock_i          (clock),
        .reset_i          (reset),
        .write_enable_i   (write_enable),
        .write_channel_i  (write_channel),
        .write_data_i     (write_data),
        .write_full_o     (write_full),
        .read_enable_i    (read_enable),
        .read_channel_i   (read_channel),
        .read_data_o      (read_data),
        .read_empty_o     (read_empty),
`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_ERROR_EN
        .write_overflow_o (write_overflow),
        .read_underflow_o (read_underflow),
`endif
        .level_o          (level)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drivers: inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [1:0] ch, input logic [7:0] data);
        write_enable  = 1'b1;
        write_channel = ch;
        write_data    = data;
        tick();
        write_enable  = 1'b0;
    endtask

    task automatic pop(input logic [1:0] ch);
        read_enable  = 1'b1;
        read_channel = ch;
        tick();
        read_enable  = 1'b0;
    endtask

    function automatic logic [2:0] lvl(input int c);
        return level[c*3 +: 3];
    endfunction

    // Select channel, compare the head, then pop it.
    task automatic pop_expect(input logic [1:0] ch, input logic [7:0] exp, input string name);
        read_channel = ch;
        #1;
        checks++;
        if (read_data !== exp) begin
            errors++;
            $display("FAIL %s: read_data got %h expected %h", name, read_data, exp);
        end
        pop(ch);
    endtask

    task automatic test_reset();
        apply_reset();
        tick();
        checks++;
        if (read_empty !== 4'b1111) begin
            errors++;
            $display("FAIL reset_empty: got %b expected 1111", read_empty);
        end
        checks++;
        if (write_full !== 4'b0000) begin
            errors++;
            $display("FAIL reset_full: got %b expected 0000", write_full);
        end
        checks++;
        if (level !== 12'h000) begin
            errors++;
            $display("FAIL reset_level: got %h expected 000", level);
        end
`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_ERROR_EN
        checks++;
        if (write_overflow !== 4'b0000 || read_underflow !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b/%b expected 0000/0000", write_overflow, read_underflow);
        end
`endif
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        apply_reset();
        for (int i = 0; i < 4; i++) push(2'd2, vals[i]);
        checks++;
        if (write_full !== 4'b0100) begin
            errors++;
            $display("FAIL fill_full: got %b expected 0100", write_full);
        end
        checks++;
        if (lvl(2) !== 3'd4) begin
            errors++;
            $display("FAIL fill_level: got %0d expected 4", lvl(2));
        end
        push(2'd2, 8'hA5);
        checks++;
        if (lvl(2) !== 3'd4) begin
            errors++;
            $display("FAIL overflow_level: got %0d expected 4", lvl(2));
        end
`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_ERROR_EN
        checks++;
        if (write_overflow !== 4'b0100) begin
            errors++;
            $display("FAIL overflow_flag: got %b expected 0100", write_overflow);
        end
`endif
        for (int i = 0; i < 4; i++) pop_expect(2'd2, vals[i], "drain_ch2");
        checks++;
        if (read_empty !== 4'b1111) begin
            errors++;
            $display("FAIL drain_empty: got %b expected 1111", read_empty);
        end
    endtask

    task automatic test_interleave();
        apply_reset();
        push(2'd0, 8'h10);
        push(2'd3, 8'h30);
        push(2'd0, 8'h11);
        push(2'd3, 8'h31);
        checks++;
        if (level !== {3'd2, 3'd0, 3'd0, 3'd2}) begin
            errors++;
            $display("FAIL interleave_level: got %h expected %h", level, {3'd2, 3'd0, 3'd0, 3'd2});
        end
        pop_expect(2'd3, 8'h30, "interleave_ch3_0");
        pop_expect(2'd3, 8'h31, "interleave_ch3_1");
        pop_expect(2'd0, 8'h10, "interleave_ch0_0");
        pop_expect(2'd0, 8'h11, "interleave_ch0_1");
        checks++;
        if (read_empty !== 4'b1111) begin
            errors++;
            $display("FAIL interleave_empty: got %b expected 1111", read_empty);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < 4; i++) push(2'd1, 8'h40 + 8'(i));
        // push + pop on the full channel in one cycle
        write_enable  = 1'b1;
        write_channel = 2'd1;
        write_data    = 8'h99;
        read_enable   = 1'b1;
        read_channel  = 2'd1;
        tick();
        write_enable  = 1'b0;
        read_enable   = 1'b0;
        checks++;
        if (lvl(1) !== 3'd3) begin
            errors++;
            $display("FAIL full_pushpop_level: got %0d expected 3", lvl(1));
        end
        checks++;
        if (write_full !== 4'b0000) begin
            errors++;
            $display("FAIL full_pushpop_full: got %b expected 0000", write_full);
        end
`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_ERROR_EN
        checks++;
        if (write_overflow !== 4'b0010 || read_underflow !== 4'b0000) begin
            errors++;
            $display("FAIL full_pushpop_flags: got %b/%b expected 0010/0000", write_overflow, read_underflow);
        end
`endif
        // Remaining entries prove 0x99 was dropped.
        pop_expect(2'd1, 8'h41, "full_pushpop_d1");
        pop_expect(2'd1, 8'h42, "full_pushpop_d2");
        pop_expect(2'd1, 8'h43, "full_pushpop_d3");
        checks++;
        if (read_empty[1] !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop_empty: got %b expected 1", read_empty[1]);
        end
    endtask

    task automatic test_empty_push_pop();
        apply_reset();
        write_enable  = 1'b1;
        write_channel = 2'd0;
        write_data    = 8'h55;
        read_enable   = 1'b1;
        read_channel  = 2'd0;
        tick();
        write_enable  = 1'b0;
        read_enable   = 1'b0;
        checks++;
        if (lvl(0) !== 3'd1) begin
            errors++;
            $display("FAIL empty_pushpop_level: got %0d expected 1", lvl(0));
        end
`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_ERROR_EN
        checks++;
        if (read_underflow !== 4'b0001 || write_overflow !== 4'b0000) begin
            errors++;
            $display("FAIL empty_pushpop_flags: got %b/%b expected 0001/0000", read_underflow, write_overflow);
        end
`endif
        pop_expect(2'd0, 8'h55, "empty_pushpop_data");
        checks++;
        if (read_empty[0] !== 1'b1) begin
            errors++;
            $display("FAIL empty_pushpop_empty: got %b expected 1", read_empty[0]);
        end
    endtask

    task automatic test_wrap_and_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            push(2'd1, 8'(i));
            checks++;
            if (lvl(1) !== 3'd1) begin
                errors++;
                $display("FAIL wrap_level_%0d: got %0d expected 1", i, lvl(1));
            end
            pop_expect(2'd1, 8'(i), "wrap_data");
        end
        checks++;
        if (lvl(1) !== 3'd0) begin
            errors++;
            $display("FAIL wrap_final_level: got %0d expected 0", lvl(1));
        end
        // Load some state, create sticky flags, then reset with ops active.
        push(2'd0, 8'hC0);
        push(2'd3, 8'hC3);
        pop(2'd2);
        push(2'd3, 8'hC4);
        reset         = 1'b1;
        write_enable  = 1'b1;
        write_channel = 2'd2;
        write_data    = 8'hEE;
        read_enable   = 1'b1;
        read_channel  = 2'd0;
        tick();
        reset         = 1'b0;
        write_enable  = 1'b0;
        read_enable   = 1'b0;
        checks++;
        if (read_empty !== 4'b1111 || write_full !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_status: got %b/%b expected 1111/0000", read_empty, write_full);
        end
        checks++;
        if (level !== 12'h000) begin
            errors++;
            $display("FAIL midreset_level: got %h expected 000", level);
        end
`ifdef SYNCHRONOUS_MULTICHANNEL_FIFO_ERROR_EN
        checks++;
        if (write_overflow !== 4'b0000 || read_underflow !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_flags: got %b/%b expected 0000/0000", write_overflow, read_underflow);
        end
`endif
    endtask

    initial begin
        reset         = 1'b1;
        write_enable  = 1'b0;
        write_channel = 2'd0;
        write_data    = 8'h00;
        read_enable   = 1'b0;
        read_channel  = 2'd0;
        test_reset();
        test_fill_drain();
        test_interleave();
        test_full_push_pop();
        test_empty_push_pop();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
